mem_stage_nb: RTL

//  Next-generation MEM pipeline stage for a non-blocking data bus (req/addr_ok in EX, data_ok/rdata here).

---
 rtl/mem_stage_nb_pkg.sv | 35 +++
 rtl/mem_stage_nb_load_align.sv | 76 +++++++
 rtl/mem_stage_nb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_nb_pkg.sv
// Shared encodings and bus-width helpers for the non-blocking MEM stage.
package mem_stage_nb_pkg;

   // Load width encodings (ld_width field)
   localparam logic [1:0] LD_DWORD = 2'b00;
   localparam logic [1:0] LD_BYTE  = 2'b01;
   localparam logic [1:0] LD_HALF  = 2'b10;
   localparam logic [1:0] LD_WORD  = 2'b11;

   // Unaligned word load kind (ld_lr field)
   localparam logic [1:0] LR_NONE  = 2'b00;
   localparam logic [1:0] LR_LWL   = 2'b01;
   localparam logic [1:0] LR_LWR   = 2'b10;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DONE  = 2'd2
   } ms_state_e;

   function automatic int off_w(input int dw);
      return $clog2(dw / 8);
   endfunction

   // {req_sent,ex,res_from_mem,gr_we,dest,ld_width,ld_sign,ld_lr,ld_off,alu_res,pc}
   function automatic int es2ms_w(input int dw);
      return 46 + off_w(dw) + dw;
   endfunction

   // {byte_we,dest,result,pc}
   function automatic int ms2ws_w(input int dw);
      return dw / 8 + 5 + dw + 32;
   endfunction

endpackage

// File: rtl/mem_stage_nb_load_align.sv
// Combinational load data alignment: extracts and extends the addressed
// byte/half/word/dword, and shifts LWL/LWR data with matching byte enables.
module load_align
   import mem_stage_nb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]          rdata,
   input  logic [1:0]                 width,
   input  logic                       sign,
   input  logic [1:0]                 lr,
   input  logic [$clog2(DATA_W/8)-1:0] off,
   output logic [DATA_W-1:0]          result,
   output logic [DATA_W/8-1:0]        byte_we
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int NB    = DATA_W / 8;

   logic        word_idx;
   logic [1:0]  lo;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] word_v;
   logic [31:0] lr_v;
   logic [3:0]  lr_we;

   // On a 64-bit path the top offset bit picks the word; 32-bit has only one
   assign word_idx = (DATA_W == 64) ? off[OFF_W-1] : 1'b0;
   assign lo       = off[1:0];
   assign byte_v   = 8'(rdata >> {off, 3'b000});
   assign half_v   = 16'(rdata >> {off[OFF_W-1:1], 4'b0000});
   assign word_v   = 32'(rdata >> {word_idx, 5'b00000});

   // Select, shift and extend the loaded value; LWL/LWR only write part of the word
   always_comb begin
      result  = '0;
      byte_we = '1;
      lr_v    = word_v;
      lr_we   = 4'b1111;
      case (lr)
         LR_LWL: begin
            lr_v  = word_v << {~lo, 3'b000};
            lr_we = 4'b1111 << ~lo;
         end
         LR_LWR: begin
            lr_v  = word_v >> {lo, 3'b000};
            lr_we = 4'b1111 >> lo;
         end
         default: ;
      endcase
      if (lr != LR_NONE) begin
         if (sign) result = DATA_W'($signed(lr_v));
         else      result = DATA_W'(lr_v);
         byte_we = NB'(lr_we);
      end else begin
         case (width)
            LD_BYTE: begin
               if (sign) result = DATA_W'($signed(byte_v));
               else      result = DATA_W'(byte_v);
            end
            LD_HALF: begin
               if (sign) result = DATA_W'($signed(half_v));
               else      result = DATA_W'(half_v);
            end
            LD_WORD: begin
               if (sign) result = DATA_W'($signed(word_v));
               else      result = DATA_W'(word_v);
            end
            LD_DWORD: result = rdata;
            default:  result = rdata;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage_nb.sv
// MEM pipeline stage for a non-blocking data bus: holds one instruction,
// waits for the in-order load/store response, buffers it while WB stalls,
// and drops responses that belong to loads killed by a flush.
module mem_stage_nb
   import mem_stage_nb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          es_to_ms_valid,
   input  logic [es2ms_w(DATA_W)-1:0]    es_to_ms_bus,
   output logic                          ms_allowin,
   input  logic                          data_ok,
   input  logic [DATA_W-1:0]             rdata,
   input  logic                          flush,
   input  logic                          ws_allowin,
   output logic                          ms_to_ws_valid,
   output logic [ms2ws_w(DATA_W)-1:0]    ms_to_ws_bus,
   output logic                          ms_ex,
   output logic                          ms_fwd_we,
   output logic                          ms_fwd_ready,
   output logic [5+DATA_W-1:0]           ms_fwd_bus
);

   localparam int OFF_W   = off_w(DATA_W);
   localparam int NB      = DATA_W / 8;
   localparam int CNT_W   = $clog2(MAX_OUT + 1);
   localparam int ES_W    = es2ms_w(DATA_W);
   localparam int P_ALU   = 32;
   localparam int P_OFF   = P_ALU + DATA_W;
   localparam int P_LR    = P_OFF + OFF_W;
   localparam int P_SIGN  = P_LR + 2;
   localparam int P_WIDTH = P_SIGN + 1;
   localparam int P_DEST  = P_WIDTH + 2;
   localparam int P_GRWE  = P_DEST + 5;
   localparam int P_RFM   = P_GRWE + 1;
   localparam int P_EX    = P_RFM + 1;
   localparam int P_REQ   = P_EX + 1;

   ms_state_e          state_q, state_d;
   logic [CNT_W-1:0]   disc_cnt_q, disc_cnt_d;
   logic               buf_vld_q, buf_vld_d;
   logic [DATA_W-1:0]  buf_data_q, buf_data_d;
   // req_sent is only needed on the accept cycle, so it is not held
   logic [ES_W-2:0]    es_bus_q, es_bus_d;

   logic               ready_go, accept, disc_inc, disc_dec;
   logic [DATA_W-1:0]  ld_data, align_res, result;
   logic [NB-1:0]      align_we, byte_we;
   logic [31:0]        pc;
   logic [DATA_W-1:0]  alu_res;
   logic [OFF_W-1:0]   ld_off;
   logic [1:0]         ld_lr, ld_width;
   logic [4:0]         dest;
   logic               ld_sign, gr_we, res_from_mem, ex;

   assign pc           = es_bus_q[31:0];
   assign alu_res      = es_bus_q[P_ALU +: DATA_W];
   assign ld_off       = es_bus_q[P_OFF +: OFF_W];
   assign ld_lr        = es_bus_q[P_LR +: 2];
   assign ld_sign      = es_bus_q[P_SIGN];
   assign ld_width     = es_bus_q[P_WIDTH +: 2];
   assign dest         = es_bus_q[P_DEST +: 5];
   assign gr_we        = es_bus_q[P_GRWE];
   assign res_from_mem = es_bus_q[P_RFM];
   assign ex           = es_bus_q[P_EX];

   // A response only completes the held instruction once every discarded one has drained
   assign ready_go   = (state_q == ST_DONE) ||
                       (state_q == ST_WAIT && data_ok && disc_cnt_q == '0);
   assign ms_allowin = (state_q == ST_EMPTY) || (ready_go && ws_allowin);
   assign accept     = es_to_ms_valid && ms_allowin && !flush;

   // A flushed WAIT still owes a response unless that response arrives this very cycle
   assign disc_inc = flush && (state_q == ST_WAIT) && !(data_ok && disc_cnt_q == '0);
   assign disc_dec = data_ok && (disc_cnt_q != '0);

   assign ld_data = buf_vld_q ? buf_data_q : rdata;

   load_align #(.DATA_W(DATA_W)) u_align (
      .rdata   (ld_data),
      .width   (ld_width),
      .sign    (ld_sign),
      .lr      (ld_lr),
      .off     (ld_off),
      .result  (align_res),
      .byte_we (align_we)
   );

   assign result  = res_from_mem ? align_res : alu_res;
   assign byte_we = gr_we ? (res_from_mem ? align_we : '1) : '0;

   assign ms_to_ws_valid = ready_go && !flush;
   assign ms_to_ws_bus   = {byte_we, dest, result, pc};
   assign ms_ex          = (state_q != ST_EMPTY) && ex;
   assign ms_fwd_we      = (state_q != ST_EMPTY) && gr_we;
   assign ms_fwd_ready   = ready_go;
   assign ms_fwd_bus     = {dest, result};

   // Next-state: FSM, discard counter, stall buffer and instruction register
   always_comb begin
      state_d    = state_q;
      disc_cnt_d = disc_cnt_q;
      buf_vld_d  = buf_vld_q;
      buf_data_d = buf_data_q;
      es_bus_d   = es_bus_q;
      if (disc_inc && !disc_dec) disc_cnt_d = disc_cnt_q + CNT_W'(1);
      else if (disc_dec && !disc_inc) disc_cnt_d = disc_cnt_q - CNT_W'(1);
      if (flush) begin
         state_d   = ST_EMPTY;
         buf_vld_d = 1'b0;
      end else begin
         if (ready_go && ws_allowin) begin
            state_d   = ST_EMPTY;
            buf_vld_d = 1'b0;
         end else if (state_q == ST_WAIT && ready_go) begin
            state_d    = ST_DONE;
            buf_vld_d  = 1'b1;
            buf_data_d = rdata;
         end
         if (accept) begin
            es_bus_d = es_to_ms_bus[ES_W-2:0];
            state_d  = es_to_ms_bus[P_REQ] ? ST_WAIT : ST_DONE;
         end
      end
   end

   // Control state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_EMPTY;
         disc_cnt_q <= '0;
         buf_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         disc_cnt_q <= disc_cnt_d;
         buf_vld_q  <= buf_vld_d;
      end
   end

   // Data registers are qualified by control state and need no reset
   always_ff @(posedge clk) begin
      es_bus_q   <= es_bus_d;
      buf_data_q <= buf_data_d;
   end

   // The bus never has more than MAX_OUT requests in flight to discard
   always_ff @(posedge clk) begin
      if (resetn) begin
         assert (!(disc_inc && !disc_dec && disc_cnt_q == CNT_W'(MAX_OUT)));
      end
   end

endmodule
